// File: rtl/mdu.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// One PREP cycle, ITER shift-add or restoring-divide cycles, one FIX cycle.
module mdu #(
  parameter int ITER = 32,
  parameter int OP_W = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic [OP_W-1:0] op,
  input  logic [31:0]     a,
  input  logic [31:0]     b,
  input  logic            mthi,
  input  logic            mtlo,
  input  logic [31:0]     wdata,
  output logic            busy,
  output logic            done,
  output logic [31:0]     hi,
  output logic [31:0]     lo
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    RUN  = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [CW-1:0]     cnt_r;
  logic [OP_W-1:0]   op_r;
  logic [31:0]       a_r;
  logic [31:0]       b_r;
  logic [31:0]       dsr_r;
  logic [63:0]       acc_r;
  logic              neg_q_r;
  logic              neg_r_r;
  logic [31:0]       hi_r;
  logic [31:0]       lo_r;
  logic              busy_r;
  logic              done_r;

  logic              sign_a_s;
  logic              sign_b_s;
  logic [31:0]       mag_a_s;
  logic [31:0]       mag_b_s;
  logic [32:0]       mul_sum_s;
  logic [32:0]       div_diff_s;
  logic [31:0]       res_hi_s;
  logic [31:0]       res_lo_s;

  // op bit 1 selects divide, op bit 0 selects unsigned
  function automatic logic [31:0] neg32(input logic [31:0] x);
    return 32'd0 - x;
  endfunction

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = PREP;
        else       state_next_s = IDLE;
      end
      PREP: state_next_s = RUN;
      RUN: begin
        if (cnt_r == {CW{1'b0}}) state_next_s = FIX;
        else                     state_next_s = RUN;
      end
      FIX:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Operand magnitudes, one iteration step, and the sign-corrected result
  always_comb begin
    sign_a_s   = ~op_r[0] & a_r[31];
    sign_b_s   = ~op_r[0] & b_r[31];
    mag_a_s    = sign_a_s ? neg32(a_r) : a_r;
    mag_b_s    = sign_b_s ? neg32(b_r) : b_r;
    mul_sum_s  = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, dsr_r} : 33'd0);
    div_diff_s = {acc_r[63:32], acc_r[31]} - {1'b0, dsr_r};
    res_hi_s   = acc_r[63:32];
    res_lo_s   = acc_r[31:0];
    if (op_r[1]) begin
      if (b_r == 32'd0) begin
        res_hi_s = a_r;
        res_lo_s = 32'hFFFF_FFFF;
      end else begin
        res_hi_s = neg_r_r ? neg32(acc_r[63:32]) : acc_r[63:32];
        res_lo_s = neg_q_r ? neg32(acc_r[31:0])  : acc_r[31:0];
      end
    end else begin
      {res_hi_s, res_lo_s} = neg_q_r ? (64'd0 - acc_r) : acc_r;
    end
  end

  // Operand capture and iterative datapath
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r   <= {CW{1'b0}};
      op_r    <= {OP_W{1'b0}};
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      dsr_r   <= 32'd0;
      acc_r   <= 64'd0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            op_r <= op;
            a_r  <= a;
            b_r  <= b;
          end
        end
        PREP: begin
          cnt_r   <= CW'(ITER - 1);
          neg_q_r <= sign_a_s ^ sign_b_s;
          neg_r_r <= sign_a_s;
          // multiply shifts the multiplier out of acc; divide shifts the dividend out
          if (op_r[1]) begin
            dsr_r <= mag_b_s;
            acc_r <= {32'd0, mag_a_s};
          end else begin
            dsr_r <= mag_a_s;
            acc_r <= {32'd0, mag_b_s};
          end
        end
        RUN: begin
          cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
          if (op_r[1]) begin
            if (!div_diff_s[32]) acc_r <= {div_diff_s[31:0], acc_r[30:0], 1'b1};
            else                 acc_r <= {acc_r[62:0], 1'b0};
          end else begin
            acc_r <= {mul_sum_s, acc_r[31:1]};
          end
        end
        default: ;
      endcase
    end
  end

  // HI/LO registers, status outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hi_r   <= 32'd0;
      lo_r   <= 32'd0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s != IDLE);
      done_r <= (state_r == FIX);
      case (state_r)
        IDLE: begin
          if (!start) begin
            if (mthi) hi_r <= wdata;
            if (mtlo) lo_r <= wdata;
          end
        end
        FIX: begin
          hi_r <= res_hi_s;
          lo_r <= res_lo_s;
        end
        default: ;
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_mdu.sv
// Directed plus randomized bench for mdu against a plain-arithmetic model.
module tb_mdu;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        mthi, mtlo;
  logic        busy, done;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;

  mdu #(.ITER(32), .OP_W(2)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] model(input logic [1:0] mop, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, p, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (mop)
      2'b00: begin p = sx * sy; return p; end
      2'b01: return {32'd0, x} * {32'd0, y};
      2'b10: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a start for one sampling edge; returns #1 after that edge.
  task automatic launch(input logic [1:0] mop, input logic [31:0] x, input logic [31:0] y);
    @(negedge clock);
    start = 1'b1; op = mop; a = x; b = y;
    @(posedge clock); #1;
    start = 1'b0; op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
  endtask

  // Wait for done (bounded), checking latency, busy held, result, done pulse.
  task automatic finish_op(input string tag, input int elapsed, input logic [63:0] exp);
    int  n;
    bit  busy_ok;
    n = elapsed;
    busy_ok = 1'b1;
    while (n < 40) begin
      @(posedge clock); #1;
      n++;
      if (done) break;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    chk({tag, "_latency"}, 64'(n), 64'd34);
    chk({tag, "_busy_held"}, {63'd0, busy_ok}, 64'd1);
    chk({tag, "_busy_drop"}, {63'd0, busy}, 64'd0);
    chk({tag, "_hilo"}, {hi, lo}, exp);
    @(posedge clock); #1;
    chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] mop, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] exp;
    exp = model(mop, x, y);
    launch(mop, x, y);
    finish_op(tag, 0, exp);
  endtask

  initial begin
    logic [63:0] exp, keep;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    reset_n = 1'b0; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
    mthi = 1'b0; mtlo = 1'b0; wdata = 32'd0;
    #12;
    chk("reset_state", {30'd0, busy, done, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    @(negedge clock); reset_n = 1'b1;

    run_op("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'd7);
    chk("mult_neg3x7_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg7_2_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu_7_2", 2'b11, 32'd7, 32'd2);
    run_op("div_by_zero", 2'b10, 32'd1234, 32'd0);
    chk("div_by_zero_const", {hi, lo}, 64'h0000_04D2_FFFF_FFFF);
    run_op("divu_by_zero", 2'b11, 32'h8765_4321, 32'd0);
    run_op("div_overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_overflow_const", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op("div_pos_neg", 2'b10, 32'd100, 32'hFFFF_FFF9);

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op("random", rop, ra, rb);
    end

    // start and mthi re-asserted mid-RUN are ignored
    exp = model(2'b00, 32'h1234_5678, 32'hFEDC_BA98);
    launch(2'b00, 32'h1234_5678, 32'hFEDC_BA98);
    keep = {hi, lo};
    repeat (10) begin @(posedge clock); #1; end
    start = 1'b1; op = 2'b11; a = 32'd99; b = 32'd3; mthi = 1'b1; wdata = 32'd5;
    @(posedge clock); #1;
    start = 1'b0; mthi = 1'b0;
    chk("hold_hilo_until_fix", {hi, lo}, keep);
    finish_op("contention", 11, exp);
    keep = {hi, lo};
    repeat (4) begin
      @(posedge clock); #1;
      chk("no_second_op", {31'd0, busy, done, hi, lo}, {32'd0, keep});
    end
    @(negedge clock); mthi = 1'b1; wdata = 32'd5;
    @(posedge clock); #1; mthi = 1'b0;
    chk("mthi_idle", {hi, lo}, {32'd5, keep[31:0]});
    @(negedge clock); mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFE_F00D;
    @(posedge clock); #1; mthi = 1'b0; mtlo = 1'b0;
    chk("mthi_mtlo_both", {hi, lo}, 64'hCAFE_F00D_CAFE_F00D);

    // start wins over a same-cycle move
    exp = model(2'b01, 32'd9, 32'd11);
    @(negedge clock);
    start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd11; mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
    @(posedge clock); #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    chk("start_drops_move", {hi, lo}, 64'hCAFE_F00D_CAFE_F00D);
    finish_op("start_with_move", 0, exp);

    // asynchronous reset in the middle of RUN
    launch(2'b01, 32'hFFFF_0001, 32'h0000_FFFF);
    repeat (11) begin @(posedge clock); #1; end
    reset_n = 1'b0;
    #1;
    chk("midrun_reset", {30'd0, busy, done, hi}, 64'd0);
    chk("midrun_reset_lo", {32'd0, lo}, 64'd0);
    @(negedge clock); reset_n = 1'b1;
    run_op("multu_6x7", 2'b01, 32'd6, 32'd7);
    chk("multu_6x7_const", {hi, lo}, 64'd42);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
